pc_sel_reg: RTL
===============

# pc_sel_reg

Parametrised program-counter register with an N-way next-PC selector, replacing a bare combinational PC mux in the fetch stage. Each cycle it selects the sequential address or one of NSRC-1 redirect targets and registers the result as the PC. Redirects that arrive while fetch is stalled are buffered and applied when the stall releases. An exception entry path overrides everything.

## Interface
- WIDTH, 32, address width in bits
- NSRC, 4, number of next-PC sources including the internal sequential source (NSRC ≥ 2)
- SELW, 2, select width, ≥ clog2(NSRC)
- STEP, 4, sequential increment
- RESET_PC, 32'h0000_3000, PC value after reset
- EXC_PC, 32'h0000_4180, exception entry address

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC this cycle
- exc  in  1  exception entry request
- sel  in  SELW  source select; 0 = sequential (pc+STEP), k = src_bus slot k
- src_bus  in  NSRC*WIDTH  packed redirect targets; slot k occupies bits [k*WIDTH +: WIDTH]; slot 0 ignored
- pc  out  WIDTH  current PC (registered)
- pc_plus  out  WIDTH  pc+STEP (combinational from pc)
- pending  out  1  a buffered redirect is waiting
- sel_err  out  1  sticky flag: sel ≥ NSRC was seen

## Operation
- Reset (reset=1 at edge): pc=RESET_PC, pending=0, internal pend_addr=0, sel_err=0. Reset wins over every other input, including mid-stall with a redirect pending.
- Effective select: esel = sel if sel < NSRC, else 0. If sel ≥ NSRC, set sel_err=1; it stays set until reset. sel_err is set in any cycle, stalled or not.
- Candidate next: nxt = pc+STEP if esel==0, else src_bus slot esel.
- Priority per edge, highest first:
  1. exc=1: pc<=EXC_PC, pending<=0. This applies even if stall=1.
  2. stall=1, esel≠0: pc holds; pend_addr<=nxt; pending<=1. A later redirect overwrites an earlier pending one.
  3. stall=1, esel==0: pc holds; pending and pend_addr unchanged.
  4. stall=0, pending=1: pc<=pend_addr; pending<=0. The current sel is ignored that cycle.
  5. stall=0, pending=0: pc<=nxt.
- Arithmetic: pc+STEP is computed modulo 2^WIDTH. No carry out; wrap-around is silent.
- No other state. Outputs never go X after reset.

## Timing
- Latency: sel/src_bus/exc sampled at edge t appear on pc after edge t (one cycle).
- pc_plus tracks pc combinationally in the same cycle. There is no path from sel to pc_plus.
- pending rises the cycle after the stalled redirect edge. It falls after the first unstalled edge, which is the same edge that loads pend_addr.
- Stall of any length: pc is constant throughout. Only the last redirect seen during the stall is applied.
- Exc during a stall with pending=1: the pending redirect is discarded and the PC goes to EXC_PC.

## Test plan
- Reset then 3 unstalled cycles with sel=0 -> pc = 0x3000, 0x3004, 0x3008, 0x300C; pending=0, sel_err=0.
- sel=2, slot2=0x0000_3100, stall=0 -> pc=0x3100 next cycle; then sel=0 -> 0x3104.
- Sequence with stall=1:
  - cycle 1: sel=1, slot1=0x3200; cycle 2: sel=3, slot3=0x3300 -> pc holds and pending=1.
  - Then stall=0 with sel=2, slot2=0x3400 -> pc=0x3300, pending=0.
  - Next sel=0 -> pc=0x3304.
- stall=1 and sel=1 (pending=1), then exc=1 while stall=1 -> pc=0x4180, pending=0. Then stall=0, sel=0 -> pc=0x4184.
- Overrides: WIDTH=32, RESET_PC=32'hFFFF_FFFC, sel=0 -> pc wraps to 0x0000_0000. Reset asserted while pending=1 -> pc=RESET_PC, pending=0 after one edge.
- Overrides: NSRC=3, SELW=2, sel=3 -> treated as sequential (pc+4), sel_err=1 and stays 1 with sel=0 thereafter until reset.

Source files
------------

// File: rtl/pc_sel_reg.sv
// ---------------------------------------------------------------------------
// pc_sel_reg
//   Program-counter register with an NSRC-way next-PC selector for the fetch
//   stage. Each cycle the PC advances sequentially (pc + STEP) or jumps to one
//   of NSRC-1 redirect targets. A redirect that arrives while fetch is stalled
//   is parked in a one-entry buffer and applied on the first unstalled edge.
//   Exception entry overrides everything except reset.
//
// Ports
//   clk      in   1           rising-edge clock
//   reset    in   1           synchronous, active-high reset
//   stall    in   1           hold PC this cycle
//   exc      in   1           exception entry request (forces EXC_PC)
//   sel      in   SELW        0 = sequential, k = src_bus slot k
//   src_bus  in   NSRC*WIDTH  packed redirect targets, slot k at [k*WIDTH +: WIDTH]
//   pc       out  WIDTH       current PC (registered)
//   pc_plus  out  WIDTH       pc + STEP (combinational from pc only)
//   pending  out  1           a buffered redirect is waiting
//   sel_err  out  1           sticky: a select >= NSRC has been seen
// ---------------------------------------------------------------------------
module pc_sel_reg #(
    parameter int                 WIDTH    = 32,
    parameter int                 NSRC     = 4,
    parameter int                 SELW     = 2,
    parameter int                 STEP     = 4,
    parameter logic [WIDTH-1:0]   RESET_PC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0]   EXC_PC   = WIDTH'(32'h0000_4180)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  exc,
    input  logic [SELW-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] src_bus,
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      pc_plus,
    output logic                  pending,
    output logic                  sel_err
);

    localparam int NSLOT = 2 ** SELW;

    logic [WIDTH-1:0] pc_q,        pc_d;
    logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic             pending_q,   pending_d;
    logic             sel_err_q,   sel_err_d;

    logic             sel_ok_s;
    logic [SELW-1:0]  esel_s;
    logic [WIDTH-1:0] pc_plus_s;
    logic [WIDTH-1:0] nxt_s;
    logic [WIDTH-1:0] slot_s [NSLOT];

    // Sequential address; wraps silently modulo 2^WIDTH.
    always_comb begin
        pc_plus_s = pc_q + WIDTH'(STEP);
    end

    // Effective select: out-of-range selects fall back to the sequential source.
    always_comb begin
        sel_ok_s = (32'(sel) < 32'(NSRC));
        if (sel_ok_s) begin
            esel_s = sel;
        end else begin
            esel_s = {SELW{1'b0}};
        end
    end

    // Candidate next PC. Slots that do not exist are filled with the
    // sequential address; they are unreachable because esel_s < NSRC.
    always_comb begin
        for (int k = 0; k < NSLOT; k++) begin
            slot_s[k] = pc_plus_s;
        end
        for (int k = 0; k < NSRC; k++) begin
            slot_s[k] = src_bus[k*WIDTH +: WIDTH];
        end
        if (esel_s == {SELW{1'b0}}) begin
            nxt_s = pc_plus_s;
        end else begin
            nxt_s = slot_s[esel_s];
        end
    end

    // Next-state selection in priority order: exception, stalled redirect,
    // stalled sequential, release of buffered redirect, normal update.
    always_comb begin
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        pending_d   = pending_q;
        sel_err_d   = sel_err_q | ~sel_ok_s;

        if (exc) begin
            pc_d      = EXC_PC;
            pending_d = 1'b0;
        end else if (stall) begin
            if (esel_s != {SELW{1'b0}}) begin
                // Last redirect seen during a stall wins.
                pend_addr_d = nxt_s;
                pending_d   = 1'b1;
            end else begin
                pend_addr_d = pend_addr_q;
                pending_d   = pending_q;
            end
        end else if (pending_q) begin
            // Buffered redirect takes the slot; current sel is ignored.
            pc_d      = pend_addr_q;
            pending_d = 1'b0;
        end else begin
            pc_d = nxt_s;
        end
    end

    // State registers with synchronous reset overriding all other inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            pend_addr_q <= {WIDTH{1'b0}};
            pending_q   <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            pending_q   <= pending_d;
            sel_err_q   <= sel_err_d;
        end
    end

    // Output drive: all state outputs come straight from flops.
    always_comb begin
        pc      = pc_q;
        pc_plus = pc_plus_s;
        pending = pending_q;
        sel_err = sel_err_q;
    end

endmodule
